// File: rtl/hc_stream_responder.sv
// Host-channel responder: hcw->hcr loopback FIFO plus a seekable 32x32 memory.
// Single bus_clk domain, asynchronous active-low reset, quiesce flushes state.
module hc_stream_responder #(
    parameter int FIFO_AW = 4
) (
    input  logic        bus_clk,
    input  logic        trn_reset_n,
    input  logic        quiesce,
    input  logic        user_w_hcw_wren,
    input  logic [31:0] user_w_hcw_data,
    output logic        user_w_hcw_full,
    input  logic        user_w_hcw_open,
    input  logic        user_r_hcr_rden,
    output logic [31:0] user_r_hcr_data,
    output logic        user_r_hcr_empty,
    output logic        user_r_hcr_eof,
    input  logic        user_r_hcr_open,
    input  logic        user_w_hc_dpram_wren,
    input  logic [31:0] user_w_hc_dpram_data,
    output logic        user_w_hc_dpram_full,
    input  logic        user_w_hc_dpram_open,
    input  logic        user_r_hc_dpram_rden,
    output logic [31:0] user_r_hc_dpram_data,
    output logic        user_r_hc_dpram_empty,
    output logic        user_r_hc_dpram_eof,
    input  logic        user_r_hc_dpram_open,
    input  logic [4:0]  user_hc_dpram_addr,
    input  logic        user_hc_dpram_addr_update
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] LP_DEPTH = (FIFO_AW + 1)'(DEPTH);

    logic [31:0]        r_fifo [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic [31:0]        r_hcr_data;
    logic               r_hcw_was_opened;
    logic               r_hcr_open_d;

    logic [31:0]        r_mem [32];
    logic [4:0]         r_addr_q;
    logic [31:0]        r_dp_data;

    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_rd;
    logic w_dp_access;
    logic w_unused_ok;

    assign w_full  = (r_count == LP_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_wr    = user_w_hcw_wren && !w_full && !quiesce;
    assign w_rd    = user_r_hcr_rden && !w_empty && !quiesce;

    assign user_w_hcw_full  = w_full;
    assign user_r_hcr_empty = w_empty;
    assign user_r_hcr_data  = r_hcr_data;
    assign user_r_hcr_eof   = w_empty && user_r_hcr_open &&
                              !user_w_hcw_open && r_hcw_was_opened;

    assign user_w_hc_dpram_full  = 1'b0;
    assign user_r_hc_dpram_empty = 1'b0;
    assign user_r_hc_dpram_eof   = 1'b0;
    assign user_r_hc_dpram_data  = r_dp_data;

    assign w_dp_access = user_w_hc_dpram_wren || user_r_hc_dpram_rden;
    assign w_unused_ok = user_w_hc_dpram_open ^ user_r_hc_dpram_open;

    // FIFO storage has no reset; only pointers and count define its contents
    always_ff @(posedge bus_clk) begin
        if (w_wr) begin
            r_fifo[r_wr_ptr] <= user_w_hcw_data;
        end
    end

    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_hcr_data <= '0;
        end else if (quiesce) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr   <= r_rd_ptr + FIFO_AW'(1);
                r_hcr_data <= r_fifo[r_rd_ptr];
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (FIFO_AW + 1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Remembers a writer was seen so eof only fires after a real stream
    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            r_hcw_was_opened <= 1'b0;
            r_hcr_open_d     <= 1'b0;
        end else begin
            r_hcr_open_d <= user_r_hcr_open;
            if (quiesce) begin
                r_hcw_was_opened <= 1'b0;
            end else if (user_w_hcw_open) begin
                r_hcw_was_opened <= 1'b1;
            end else if (r_hcr_open_d && !user_r_hcr_open) begin
                r_hcw_was_opened <= 1'b0;
            end
        end
    end

    always_ff @(posedge bus_clk) begin
        if (user_w_hc_dpram_wren) begin
            r_mem[r_addr_q] <= user_w_hc_dpram_data;
        end
    end

    // Seek load wins over auto-increment; the access itself uses the old address
    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            r_addr_q  <= '0;
            r_dp_data <= '0;
        end else begin
            if (user_r_hc_dpram_rden) begin
                r_dp_data <= r_mem[r_addr_q];
            end
            if (quiesce) begin
                r_addr_q <= '0;
            end else if (user_hc_dpram_addr_update) begin
                r_addr_q <= user_hc_dpram_addr;
            end else if (w_dp_access) begin
                r_addr_q <= r_addr_q + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_hc_stream_responder.sv
// Scoreboard bench for hc_stream_responder: stimulus pushes expected reads,
// a negedge monitor pops and compares when a read result is due.
module tb_hc_stream_responder;

    logic        bus_clk = 1'b0;
    logic        trn_reset_n;
    logic        quiesce;
    logic        user_w_hcw_wren;
    logic [31:0] user_w_hcw_data;
    logic        user_w_hcw_full;
    logic        user_w_hcw_open;
    logic        user_r_hcr_rden;
    logic [31:0] user_r_hcr_data;
    logic        user_r_hcr_empty;
    logic        user_r_hcr_eof;
    logic        user_r_hcr_open;
    logic        user_w_hc_dpram_wren;
    logic [31:0] user_w_hc_dpram_data;
    logic        user_w_hc_dpram_full;
    logic        user_w_hc_dpram_open;
    logic        user_r_hc_dpram_rden;
    logic [31:0] user_r_hc_dpram_data;
    logic        user_r_hc_dpram_empty;
    logic        user_r_hc_dpram_eof;
    logic        user_r_hc_dpram_open;
    logic [4:0]  user_hc_dpram_addr;
    logic        user_hc_dpram_addr_update;

    int checks = 0;
    int failures = 0;

    logic [31:0] fm[$];
    logic [31:0] q_fifo[$];
    logic [31:0] q_dp[$];
    logic [31:0] dmem [32];
    logic [4:0]  daddr;
    logic        exp_fifo_rd = 1'b0;
    logic        exp_dp_rd = 1'b0;
    logic        fifo_pend = 1'b0;
    logic        dp_pend = 1'b0;

    localparam logic [31:0] A = 32'hA5A5_0001;
    localparam logic [31:0] B = 32'hA5A5_0002;
    localparam logic [31:0] C = 32'hA5A5_0003;

    hc_stream_responder #(.FIFO_AW(4)) dut (
        .bus_clk                   (bus_clk),
        .trn_reset_n               (trn_reset_n),
        .quiesce                   (quiesce),
        .user_w_hcw_wren           (user_w_hcw_wren),
        .user_w_hcw_data           (user_w_hcw_data),
        .user_w_hcw_full           (user_w_hcw_full),
        .user_w_hcw_open           (user_w_hcw_open),
        .user_r_hcr_rden           (user_r_hcr_rden),
        .user_r_hcr_data           (user_r_hcr_data),
        .user_r_hcr_empty          (user_r_hcr_empty),
        .user_r_hcr_eof            (user_r_hcr_eof),
        .user_r_hcr_open           (user_r_hcr_open),
        .user_w_hc_dpram_wren      (user_w_hc_dpram_wren),
        .user_w_hc_dpram_data      (user_w_hc_dpram_data),
        .user_w_hc_dpram_full      (user_w_hc_dpram_full),
        .user_w_hc_dpram_open      (user_w_hc_dpram_open),
        .user_r_hc_dpram_rden      (user_r_hc_dpram_rden),
        .user_r_hc_dpram_data      (user_r_hc_dpram_data),
        .user_r_hc_dpram_empty     (user_r_hc_dpram_empty),
        .user_r_hc_dpram_eof       (user_r_hc_dpram_eof),
        .user_r_hc_dpram_open      (user_r_hc_dpram_open),
        .user_hc_dpram_addr        (user_hc_dpram_addr),
        .user_hc_dpram_addr_update (user_hc_dpram_addr_update)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge bus_clk) begin
        fifo_pend <= exp_fifo_rd;
        dp_pend   <= exp_dp_rd;
    end

    always @(negedge bus_clk) begin
        if (fifo_pend) begin
            if (q_fifo.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL hcr_sb: read result with no expected entry");
            end else begin
                chk("hcr_data", user_r_hcr_data, q_fifo.pop_front());
            end
        end
        if (dp_pend) begin
            if (q_dp.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dp_sb: read result with no expected entry");
            end else begin
                chk("dpram_data", user_r_hc_dpram_data, q_dp.pop_front());
            end
        end
    end

    task automatic step(input logic wr, input logic [31:0] wd, input logic rd,
                        input logic dw, input logic [31:0] dd, input logic dr,
                        input logic upd, input logic [4:0] ad,
                        input logic qz);
        bit wacc;
        bit racc;
        wacc = wr && (fm.size() < 16);
        racc = rd && (fm.size() > 0);
        if (qz) begin
            fm.delete();
            wacc = 0;
            racc = 0;
        end
        if (racc) q_fifo.push_back(fm.pop_front());
        if (wacc) fm.push_back(wd);
        exp_fifo_rd = racc;
        if (dr) q_dp.push_back(dmem[daddr]);
        if (dw) dmem[daddr] = dd;
        if (qz) daddr = 5'd0;
        else if (upd) daddr = ad;
        else if (dw || dr) daddr = daddr + 5'd1;
        exp_dp_rd = dr;
        user_w_hcw_wren = wr;
        user_w_hcw_data = wd;
        user_r_hcr_rden = rd;
        user_w_hc_dpram_wren = dw;
        user_w_hc_dpram_data = dd;
        user_r_hc_dpram_rden = dr;
        user_hc_dpram_addr_update = upd;
        user_hc_dpram_addr = ad;
        quiesce = qz;
        @(posedge bus_clk);
        #1;
        user_w_hcw_wren = 0;
        user_r_hcr_rden = 0;
        user_w_hc_dpram_wren = 0;
        user_r_hc_dpram_rden = 0;
        user_hc_dpram_addr_update = 0;
        quiesce = 0;
        exp_fifo_rd = 0;
        exp_dp_rd = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic fw(input logic [31:0] d);
        step(1, d, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic fr();
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic dwr(input logic [31:0] d);
        step(0, 0, 0, 1, d, 0, 0, 0, 0);
    endtask
    task automatic drd();
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask
    task automatic seek(input logic [4:0] a);
        step(0, 0, 0, 0, 0, 0, 1, a, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) dmem[i] = '0;
        daddr = 5'd0;
        trn_reset_n = 0;
        quiesce = 0;
        user_w_hcw_wren = 0;
        user_w_hcw_data = 0;
        user_w_hcw_open = 0;
        user_r_hcr_rden = 0;
        user_r_hcr_open = 0;
        user_w_hc_dpram_wren = 0;
        user_w_hc_dpram_data = 0;
        user_w_hc_dpram_open = 0;
        user_r_hc_dpram_rden = 0;
        user_r_hc_dpram_open = 0;
        user_hc_dpram_addr = 0;
        user_hc_dpram_addr_update = 0;
        #3;
        chk("rst_full", user_w_hcw_full, 0);
        chk("rst_empty", user_r_hcr_empty, 1);
        chk("rst_eof", user_r_hcr_eof, 0);
        chk("rst_hcr_data", user_r_hcr_data, 0);
        chk("rst_dp_data", user_r_hc_dpram_data, 0);
        chk("dp_full", user_w_hc_dpram_full, 0);
        chk("dp_empty", user_r_hc_dpram_empty, 0);
        chk("dp_eof", user_r_hc_dpram_eof, 0);
        #9 trn_reset_n = 1;
        @(posedge bus_clk);
        #1;

        // fill to full, overflow ignored, drain in order
        for (int i = 1; i <= 16; i++) begin
            chk("not_full", user_w_hcw_full, 0);
            fw(32'(i));
        end
        chk("full16", user_w_hcw_full, 1);
        chk("nempty16", user_r_hcr_empty, 0);
        fw(32'h99);
        chk("full17", user_w_hcw_full, 1);
        for (int i = 1; i <= 16; i++) fr();
        chk("drained", user_r_hcr_empty, 1);
        chk("drain_nfull", user_w_hcw_full, 0);
        fr();
        chk("hold_on_empty", user_r_hcr_data, 32'h10);

        // steady-state streaming across pointer wrap
        for (int i = 0; i < 8; i++) fw(32'h100 + 32'(i));
        for (int i = 0; i < 20; i++)
            step(1, 32'h200 + 32'(i), 1, 0, 0, 0, 0, 0, 0);
        chk("stream_nfull", user_w_hcw_full, 0);
        for (int i = 0; i < 7; i++) fr();
        chk("stream_one_left", user_r_hcr_empty, 0);
        fr();
        chk("stream_empty", user_r_hcr_empty, 1);
        chk("stream_last", user_r_hcr_data, 32'h213);

        // end-of-file handling
        user_w_hcw_open = 1;
        user_r_hcr_open = 1;
        idle();
        chk("eof_wopen", user_r_hcr_eof, 0);
        fw(32'hE1);
        fw(32'hE2);
        user_w_hcw_open = 0;
        idle();
        chk("eof_data_left", user_r_hcr_eof, 0);
        fr();
        chk("eof_one_left", user_r_hcr_eof, 0);
        fr();
        chk("eof_empty", user_r_hcr_empty, 1);
        chk("eof_set", user_r_hcr_eof, 1);
        user_w_hcw_open = 1;
        #1;
        chk("eof_reopen", user_r_hcr_eof, 0);
        user_w_hcw_open = 0;
        #1;
        chk("eof_reclose", user_r_hcr_eof, 1);
        user_r_hcr_open = 0;
        idle();
        chk("eof_rclosed", user_r_hcr_eof, 0);
        user_r_hcr_open = 1;
        idle();
        chk("eof_flag_clr", user_r_hcr_eof, 0);
        user_r_hcr_open = 0;

        // seekable memory with address wrap
        seek(5'd30);
        dwr(A);
        dwr(B);
        dwr(C);
        seek(5'd30);
        drd();
        drd();
        drd();
        chk("dp_wrap_C", user_r_hc_dpram_data, C);

        // seek in same cycle as write
        seek(5'd5);
        step(0, 0, 0, 1, 32'h0000_0555, 0, 1, 5'd12, 0);
        dwr(32'h0000_0CCC);
        seek(5'd5);
        drd();
        chk("dp_at5", user_r_hc_dpram_data, 32'h0000_0555);
        seek(5'd12);
        step(0, 0, 0, 1, 32'h0000_0DDD, 1, 0, 0, 0);
        chk("dp_rw_old", user_r_hc_dpram_data, 32'h0000_0CCC);
        drd();
        seek(5'd12);
        drd();
        chk("dp_rw_new", user_r_hc_dpram_data, 32'h0000_0DDD);

        // quiesce flushes FIFO and address, beats a same-cycle write
        fw(32'h31);
        fw(32'h32);
        fw(32'h33);
        step(1, 32'h34, 0, 0, 0, 0, 0, 0, 1);
        chk("qz_empty", user_r_hcr_empty, 1);
        fw(32'h55);
        fr();
        chk("qz_after", user_r_hcr_data, 32'h55);
        drd();
        chk("qz_addr0", user_r_hc_dpram_data, C);

        // async reset mid-stream, memory retained
        for (int i = 0; i < 5; i++) fw(32'h70 + 32'(i));
        seek(5'd7);
        #2 trn_reset_n = 0;
        #1;
        chk("arst_empty", user_r_hcr_empty, 1);
        chk("arst_full", user_w_hcw_full, 0);
        chk("arst_hcr", user_r_hcr_data, 0);
        chk("arst_dp", user_r_hc_dpram_data, 0);
        fm.delete();
        daddr = 5'd0;
        #2 trn_reset_n = 1;
        @(posedge bus_clk);
        #1;
        drd();
        chk("arst_mem0", user_r_hc_dpram_data, C);
        drd();
        chk("arst_mem1", user_r_hc_dpram_data, 32'h0);

        repeat (4) idle();
        checks++;
        if (q_fifo.size() != 0 || q_dp.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d hcr and %0d dpram expected reads unseen",
                     q_fifo.size(), q_dp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hc_stream_responder.md
HC_STREAM_RESPONDER -- requirements
Module: hc_stream_responder

Interface
REQ-001 SHALL have parameter FIFO_AW, default 4, meaning log2 of hcw->hcr loopback FIFO depth (depth 16).
REQ-002 SHALL have port bus_clk, input, 1, meaning single clock for all logic (Xillybus bus clock).
REQ-003 SHALL have port trn_reset_n, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port quiesce, input, 1, meaning core quiesced, which synchronously flushes state.
REQ-005 SHALL have port user_w_hcw_wren, input, 1, meaning host write strobe, data valid same cycle.
REQ-006 SHALL have port user_w_hcw_data, input, 32, meaning host write word.
REQ-007 SHALL have port user_w_hcw_full, output, 1, meaning FIFO cannot accept a word.
REQ-008 SHALL have port user_w_hcw_open, input, 1, meaning host write file open.
REQ-009 SHALL have port user_r_hcr_rden, input, 1, meaning host read strobe.
REQ-010 SHALL have port user_r_hcr_data, output, 32, meaning read word, valid cycle after rden.
REQ-011 SHALL have port user_r_hcr_empty, output, 1, meaning no word available.
REQ-012 SHALL have port user_r_hcr_eof, output, 1, meaning end of stream.
REQ-013 SHALL have port user_r_hcr_open, input, 1, meaning host read file open.
REQ-014 SHALL have ports user_w_hc_dpram_wren/data[31:0]/open, inputs, meaning seekable memory write stream.
REQ-015 SHALL have port user_w_hc_dpram_full, output, 1, meaning tied 0.
REQ-016 SHALL have ports user_r_hc_dpram_rden/open, inputs, 1, meaning seekable memory read strobe / file open.
REQ-017 SHALL have ports user_r_hc_dpram_data[31:0], user_r_hc_dpram_empty, user_r_hc_dpram_eof, outputs, meaning memory read word; empty and eof tied 0.
REQ-018 SHALL have ports user_hc_dpram_addr[4:0] and user_hc_dpram_addr_update, inputs, meaning seek address and load strobe.

Function -- loopback FIFO (hcw -> hcr)
REQ-019 SHALL store words in a 2^FIFO_AW x 32 circular buffer with wr/rd pointers plus an occupancy counter of FIFO_AW+1 bits.
REQ-020 SHALL write on wren when not full; SHALL ignore wren while full, with no pointer or count change.
REQ-021 SHALL, on rden when not empty, present the head word on user_r_hcr_data exactly one cycle later and hold it until the next accepted rden.
REQ-022 SHALL ignore rden while empty, leaving data unchanged.
REQ-023 SHALL keep count unchanged on simultaneous accepted wren and rden; a write to an empty FIFO SHALL NOT be readable in the same cycle.
REQ-024 SHALL drive full and empty combinationally from count (count==depth, count==0); pointers SHALL wrap from depth-1 to 0.
REQ-025 SHALL assert eof when empty && user_r_hcr_open && !user_w_hcw_open && hcw_was_opened, where hcw_was_opened is a flag set while user_w_hcw_open=1 and cleared when user_r_hcr_open falls.
REQ-026 SHALL, on quiesce=1, clear pointers, count and hcw_was_opened in the same clock edge, taking priority over wren/rden.

Function -- seekable 32x32 memory (hc_dpram)
REQ-027 SHALL hold a 5-bit address pointer addr_q.
REQ-028 SHALL write user_w_hc_dpram_data to mem[addr_q] on wren, and register mem[addr_q] into user_r_hc_dpram_data on rden (1-cycle latency).
REQ-029 SHALL increment addr_q by 1 modulo 32 (31 -> 0) on any cycle with wren or rden; simultaneous wren and rden SHALL target the same address, return the old contents, and increment once.
REQ-030 SHALL, on addr_update=1, load addr_q from user_hc_dpram_addr; the load overrides the increment, while a same-cycle wren/rden SHALL still use the old addr_q.
REQ-031 SHALL NOT clear memory contents on reset or quiesce; addr_q SHALL clear to 0 on quiesce.

Reset
REQ-032 SHALL, on trn_reset_n=0, asynchronously clear FIFO pointers, count, hcw_was_opened, addr_q, user_r_hcr_data and user_r_hc_dpram_data to 0.
REQ-033 SHALL show outputs in reset as: full=0, empty=1, eof=0, dpram_full=0, dpram_empty=0, dpram_eof=0.
REQ-034 SHALL resume operation on the first bus_clk edge after trn_reset_n deasserts; reset mid-transfer SHALL discard FIFO contents.

Verification
REQ-035 SHALL cover: write 0x1..0x10 (16 words) -> full=1 after the 16th; a 17th wren is ignored; 16 rden return 0x1..0x10 in order, each 1 cycle after its rden, then empty=1.
REQ-036 SHALL cover: FIFO holding 8 words, 20 cycles of simultaneous wren+rden -> count stays 8, order preserved across pointer wrap.
REQ-037 SHALL cover: open hcw and hcr, write 2 words, close hcw, read 2 -> eof=1 the cycle empty rises; reopening hcw drops eof.
REQ-038 SHALL cover: addr_update with addr=30, write A,B,C -> mem[30]=A, mem[31]=B, mem[0]=C; seek 30, read 3 -> A,B,C.
REQ-039 SHALL cover: addr_update in the same cycle as wren at addr_q=5, new addr=12 -> write lands at 5, next write at 12.
REQ-040 SHALL cover: trn_reset_n pulsed low mid-stream with 5 words queued -> empty=1, addr_q=0 immediately (asynchronously); memory contents are retained.
